// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage: instruction fetch with a 1-entry skid buffer and redirects.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [63:0] id_pc,
    output logic [63:0] id_pc_next
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT_ID = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        started_q, started_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] drop_pc_q, drop_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [63:0] id_pc_next_q, id_pc_next_d;

    logic [63:0] w_redir_pc;
    logic        w_slot_free;

    assign w_redir_pc  = redirect_pc & ~64'd3;
    assign w_slot_free = !id_valid_q || id_ready;

    // No request until one edge after reset release, so stale acks are ignored.
    assign imem_req       = started_q && (state_q != S_WAIT_ID);
    assign imem_addr      = addr_q;
    assign id_valid       = id_valid_q;
    assign id_instruction = id_instr_q;
    assign id_pc          = id_pc_q;
    assign id_pc_next     = id_pc_next_q;

    always_comb begin
        state_d      = state_q;
        started_d    = 1'b1;
        addr_d       = addr_q;
        drop_pc_d    = drop_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc_next_d = id_pc_next_q;

        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (started_q) begin
                    if (redirect_valid) begin
                        id_valid_d = 1'b0;
                        if (imem_ack) begin
                            addr_d = w_redir_pc;
                        end else begin
                            drop_pc_d = w_redir_pc;
                            state_d   = S_DROP;
                        end
                    end else if (imem_ack) begin
                        addr_d = addr_q + PC_STEP;
                        if (w_slot_free) begin
                            id_valid_d   = 1'b1;
                            id_instr_d   = imem_rdata;
                            id_pc_d      = addr_q;
                            id_pc_next_d = addr_q + PC_STEP;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = addr_q;
                            state_d      = S_WAIT_ID;
                        end
                    end
                end
            end
            S_WAIT_ID: begin
                if (redirect_valid) begin
                    id_valid_d   = 1'b0;
                    skid_instr_d = 32'd0;
                    skid_pc_d    = 64'd0;
                    addr_d       = w_redir_pc;
                    state_d      = S_REQ;
                end else if (id_ready) begin
                    id_valid_d   = 1'b1;
                    id_instr_d   = skid_instr_q;
                    id_pc_d      = skid_pc_q;
                    id_pc_next_d = skid_pc_q + PC_STEP;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                // The in-flight response belongs to the abandoned path.
                if (redirect_valid) begin
                    id_valid_d = 1'b0;
                    if (imem_ack) begin
                        addr_d  = w_redir_pc;
                        state_d = S_REQ;
                    end else begin
                        drop_pc_d = w_redir_pc;
                    end
                end else if (imem_ack) begin
                    addr_d  = drop_pc_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            started_q    <= 1'b0;
            addr_q       <= RESET_PC;
            drop_pc_q    <= 64'd0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 64'd0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'd0;
            id_pc_q      <= 64'd0;
            id_pc_next_q <= 64'd0;
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            addr_q       <= addr_d;
            drop_pc_q    <= drop_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc_next_q <= id_pc_next_d;
        end
    end

endmodule
`default_nettype wire
